// File: rtl/iter_exec_unit.sv
// iter_exec_unit: iterative integer execution unit.
//
// Executes one operation at a time. Single-cycle results (ALU non-shift,
// BRANCH, SHADD) are computed when the operation is accepted and leave after
// one RUN cycle. Shifts move at most SHIFT_STEP bits per RUN cycle. MUL is a
// radix-2 shift-add that stops as soon as the remaining multiplier bits are zero.
//
// Handshake: an operation is accepted on a rising edge where start=1 and the
// unit is not in RUN (IDLE or DONE). busy is high for the whole of RUN. done
// pulses for one cycle with out valid. out holds its value until the next
// operation completes. Starts seen while busy are ignored.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           operation request
//   mode[1:0]       0=ALU, 1=BRANCH, 2=SHADD, 3=MUL
//   f3[2:0]         funct3 (ALU/BRANCH) or SHADD shift select
//   arith_bit       SUB (f3=000) / SRA (f3=101) select
//   src_a, src_b    operands
//   out             registered result
//   busy, done      status
//   dbg_state[1:0]  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module iter_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter bit MUL_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [2:0]      f3,
    input  logic            arith_bit,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] out,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] K_SINGLE = 3'd0;
    localparam logic [2:0] K_SLL    = 3'd1;
    localparam logic [2:0] K_SRL    = 3'd2;
    localparam logic [2:0] K_SRA    = 3'd3;
    localparam logic [2:0] K_MUL    = 3'd4;

    localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

    logic [1:0]      state_q, state_d;
    logic [2:0]      kind_q, kind_d;
    logic [XLEN-1:0] work_q, work_d;   // shift operand, multiplicand, or staged result
    logic [XLEN-1:0] acc_q, acc_d;     // multiply accumulator
    logic [XLEN-1:0] mplr_q, mplr_d;   // remaining multiplier bits
    logic [XLEN-1:0] out_q, out_d;
    logic [SHW-1:0]  cnt_q, cnt_d;     // remaining shift amount

    logic            accept;
    logic [2:0]      new_kind;
    logic [XLEN-1:0] single_res;
    logic            taken;
    logic [SHW-1:0]  step;
    logic            finish;
    logic [XLEN-1:0] res;
    logic signed [XLEN-1:0] work_sra;

    assign accept = start && (state_q != S_RUN);

    // Decode of the operation presented on the inputs.
    always_comb begin
        single_res = '0;
        new_kind   = K_SINGLE;
        taken      = 1'b0;
        case (mode)
            2'd0: begin
                case (f3)
                    3'b000: single_res = arith_bit ? (src_a - src_b) : (src_a + src_b);
                    3'b001: new_kind = K_SLL;
                    3'b010: single_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                    3'b011: single_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                    3'b100: single_res = src_a ^ src_b;
                    3'b101: new_kind = arith_bit ? K_SRA : K_SRL;
                    3'b110: single_res = src_a | src_b;
                    default: single_res = src_a & src_b;
                endcase
            end
            2'd1: begin
                case (f3)
                    3'b000: taken = (src_a == src_b);
                    3'b001: taken = (src_a != src_b);
                    3'b100: taken = ($signed(src_a) < $signed(src_b));
                    3'b101: taken = ($signed(src_a) >= $signed(src_b));
                    3'b110: taken = (src_a < src_b);
                    3'b111: taken = (src_a >= src_b);
                    default: taken = 1'b0;
                endcase
                single_res = {{(XLEN-1){1'b0}}, taken};
            end
            2'd2: single_res = (src_a << f3[2:1]) + src_b;
            default: begin
                // Without the multiplier the result stays zero with latency 1.
                if (MUL_EN) new_kind = K_MUL;
            end
        endcase
    end

    // The last shift step may be shorter than SHIFT_STEP.
    assign step     = (cnt_q > STEP) ? STEP : cnt_q;
    assign work_sra = $signed(work_q) >>> step;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        work_d  = work_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        finish  = 1'b0;
        res     = work_q;

        case (state_q)
            S_RUN: begin
                case (kind_q)
                    K_SLL, K_SRL, K_SRA: begin
                        if (kind_q == K_SLL)      work_d = work_q << step;
                        else if (kind_q == K_SRL) work_d = work_q >> step;
                        else                      work_d = work_sra;
                        cnt_d  = cnt_q - step;
                        finish = (cnt_q <= STEP);
                        res    = work_d;
                    end
                    K_MUL: begin
                        if (mplr_q[0]) acc_d = acc_q + work_q;
                        work_d = work_q << 1;
                        mplr_d = mplr_q >> 1;
                        // Stop once no set multiplier bits remain above this one.
                        finish = (mplr_q[XLEN-1:1] == '0);
                        res    = acc_d;
                    end
                    default: finish = 1'b1;
                endcase
                if (finish) begin
                    state_d = S_DONE;
                    out_d   = res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Acceptance is only possible outside RUN, so it never collides with a step.
        if (accept) begin
            state_d = S_RUN;
            kind_d  = new_kind;
            work_d  = (new_kind == K_SINGLE) ? single_res : src_a;
            acc_d   = '0;
            mplr_d  = src_b;
            cnt_d   = src_b[SHW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_SINGLE;
            work_q  <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out       = out_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_iter_exec_unit.sv
// Bench for iter_exec_unit: two instances (SHIFT_STEP=1 and SHIFT_STEP=4),
// a behavioural reference model, a per-cycle compare process, directed
// literal cases and randomized traffic.
module tb_iter_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_r[2];
    logic [1:0]  mode_r[2];
    logic [2:0]  f3_r[2];
    logic        ar_r[2];
    logic [31:0] a_r[2];
    logic [31:0] b_r[2];
    logic [31:0] out_w[2];
    logic        busy_w[2];
    logic        done_w[2];
    logic [1:0]  state_w[2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iter_exec_unit #(.XLEN(32), .SHIFT_STEP(1), .MUL_EN(1'b1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .mode(mode_r[0]), .f3(f3_r[0]),
        .arith_bit(ar_r[0]), .src_a(a_r[0]), .src_b(b_r[0]), .out(out_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .dbg_state(state_w[0])
    );

    iter_exec_unit #(.XLEN(32), .SHIFT_STEP(4), .MUL_EN(1'b1)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .mode(mode_r[1]), .f3(f3_r[1]),
        .arith_bit(ar_r[1]), .src_a(a_r[1]), .src_b(b_r[1]), .out(out_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .dbg_state(state_w[1])
    );

    // ---------------- reference model ----------------
    function automatic int step_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] m, input logic [2:0] f,
                                               input logic ar, input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        logic signed [31:0] sa;
        sh = int'(b[4:0]);
        sa = a;
        case (m)
            2'd0: begin
                case (f)
                    3'd0: return ar ? a - b : a + b;
                    3'd1: return a << sh;
                    3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: return (a < b) ? 32'd1 : 32'd0;
                    3'd4: return a ^ b;
                    3'd5: begin
                        if (ar) begin
                            sa = sa >>> sh;
                            return sa;
                        end
                        return a >> sh;
                    end
                    3'd6: return a | b;
                    default: return a & b;
                endcase
            end
            2'd1: begin
                case (f)
                    3'd0: return (a == b) ? 32'd1 : 32'd0;
                    3'd1: return (a != b) ? 32'd1 : 32'd0;
                    3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd5: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
                    3'd6: return (a < b) ? 32'd1 : 32'd0;
                    3'd7: return (a >= b) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
            end
            2'd2: return (a << f[2:1]) + b;
            default: return a * b;
        endcase
    endfunction

    function automatic int ref_latency(input int st, input logic [1:0] m, input logic [2:0] f,
                                       input logic [31:0] b);
        int l;
        l = 1;
        if (m == 2'd0 && (f == 3'd1 || f == 3'd5)) begin
            l = (int'(b[4:0]) + st - 1) / st;
        end else if (m == 2'd3) begin
            l = 0;
            for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
        end
        return (l < 1) ? 1 : l;
    endfunction

    int          m_rem[2]  = '{0, 0};
    logic        m_done[2] = '{1'b0, 1'b0};
    logic [31:0] m_out[2]  = '{32'd0, 32'd0};
    logic [31:0] m_res[2]  = '{32'd0, 32'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_rem[d]  <= 0;
                m_done[d] <= 1'b0;
                m_out[d]  <= 32'd0;
                m_res[d]  <= 32'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_rem[d] > 0) begin
                    m_rem[d] <= m_rem[d] - 1;
                    if (m_rem[d] == 1) begin
                        m_done[d] <= 1'b1;
                        m_out[d]  <= m_res[d];
                    end
                end else begin
                    m_done[d] <= 1'b0;
                    if (start_r[d]) begin
                        m_res[d] <= ref_result(mode_r[d], f3_r[d], ar_r[d], a_r[d], b_r[d]);
                        m_rem[d] <= ref_latency(step_of(d), mode_r[d], f3_r[d], b_r[d]);
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d busy", d), 64'(busy_w[d]), 64'(m_rem[d] > 0));
            check($sformatf("dut%0d done", d), 64'(done_w[d]), 64'(m_done[d]));
            if (m_rem[d] == 0) check($sformatf("dut%0d out", d), 64'(out_w[d]), 64'(m_out[d]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int d, input logic [1:0] m, input logic [2:0] f, input logic ar,
                          input logic [31:0] a, input logic [31:0] b);
        mode_r[d] = m;
        f3_r[d]   = f;
        ar_r[d]   = ar;
        a_r[d]    = a;
        b_r[d]    = b;
    endtask

    // Waits (bounded) for done after an acceptance edge; returns cycles counted.
    task automatic wait_done(input int d, output int k, output bit seen);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (done_w[d]) seen = 1'b1;
        end
    endtask

    task automatic run_op(input int d, input string name, input logic [1:0] m, input logic [2:0] f,
                          input logic ar, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input int exp_lat);
        int  k;
        bit  seen;
        @(negedge clk);
        set_op(d, m, f, ar, a, b);
        start_r[d] = 1'b1;
        @(posedge clk);
        #1;
        start_r[d] = 1'b0;
        wait_done(d, k, seen);
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " out"}, 64'(out_w[d]), 64'(exp_out));
        check({name, " latency"}, 64'(k), 64'(exp_lat));
    endtask

    task automatic random_traffic(input int d, input int cycles);
        int guard;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            start_r[d] = ($urandom_range(0, 3) != 0);
            set_op(d, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom);
            if (mode_r[d] == 2'd3 || $urandom_range(0, 3) == 0) b_r[d] = b_r[d] >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b_r[d] = a_r[d];
        end
        @(negedge clk);
        start_r[d] = 1'b0;
        guard = 0;
        while (busy_w[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("dut%0d drain", d), 64'(busy_w[d]), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  k;
        bit  seen;
        for (int d = 0; d < 2; d++) begin
            start_r[d] = 1'b0;
            set_op(d, 2'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        end
        repeat (3) @(negedge clk);
        check("reset out", 64'(out_w[0]), 64'd0);
        check("reset state", 64'(state_w[0]), 64'd0);
        rst_n = 1'b1;

        // Directed literal cases.
        run_op(0, "sra step1", 2'd0, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
        run_op(1, "sll31 step4", 2'd0, 3'b001, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 8);
        run_op(1, "sll0 step4", 2'd0, 3'b001, 1'b0, 32'd1, 32'd0, 32'd1, 1);
        run_op(1, "sll upper b ignored", 2'd0, 3'b001, 1'b0, 32'd1, 32'h0000_0021, 32'd2, 1);
        run_op(1, "sra6 step4", 2'd0, 3'b101, 1'b1, 32'h8000_0000, 32'd6, 32'hFE00_0000, 2);
        run_op(0, "mul x3", 2'd3, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 2);
        run_op(0, "mul x0", 2'd3, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
        run_op(0, "blt", 2'd1, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op(0, "bltu", 2'd1, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op(0, "sub", 2'd0, 3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run_op(0, "slt", 2'd0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op(0, "sltu", 2'd0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);

        // Start held through a shift is ignored, then taken in the DONE cycle.
        @(negedge clk);
        set_op(0, 2'd0, 3'b101, 1'b0, 32'h0000_00F0, 32'd4);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        set_op(0, 2'd2, 3'b010, 1'b1, 32'd3, 32'd1);
        wait_done(0, k, seen);
        check("b2b first done seen", 64'(seen), 64'd1);
        check("b2b first out", 64'(out_w[0]), 64'h0000_000F);
        check("b2b first latency", 64'(k), 64'd4);
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        check("b2b no bubble busy", 64'(busy_w[0]), 64'd1);
        @(posedge clk);
        #1;
        check("b2b second done", 64'(done_w[0]), 64'd1);
        check("b2b second out", 64'(out_w[0]), 64'd7);

        // Asynchronous reset in the middle of a long multiply.
        @(negedge clk);
        set_op(0, 2'd3, 3'd0, 1'b0, 32'h0001_2345, 32'hFFFF_FFFF);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset out", 64'(out_w[0]), 64'd0);
        check("async reset busy", 64'(busy_w[0]), 64'd0);
        check("async reset done", 64'(done_w[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(0, "add after reset", 2'd0, 3'b000, 1'b0, 32'd2, 32'd3, 32'd5, 1);

        // Randomized traffic against the model on both step sizes.
        random_traffic(0, 600);
        random_traffic(1, 600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iter_exec_unit.md
ITER_EXEC_UNIT -- requirements
Module: iter_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be 32 or 64.
REQ-002 Parameter SHIFT_STEP, default 1, max bits shifted per cycle; SHALL be 1, 2, 4 or 8.
REQ-003 Parameter MUL_EN, default 1, enables iterative multiply mode.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request; operands and controls sampled when start=1 and busy=0.
REQ-007 mode  in  2  0=ALU, 1=BRANCH, 2=SHADD, 3=MUL.
REQ-008 f3  in  3  RISC-V funct3 for ALU/BRANCH; SHADD shift select.
REQ-009 arith_bit  in  1  SUB for f3=000, SRA for f3=101; ignored otherwise.
REQ-010 src_a, src_b  in  XLEN  operands.
REQ-011 out  out  XLEN  registered result; held until next accepted start.
REQ-012 busy  out  1  operation accepted and not yet done.
REQ-013 done  out  1  one-cycle pulse; out valid in that cycle.

Function
REQ-014 FSM states IDLE, RUN, DONE; start accepted in IDLE or DONE moves to RUN, else DONE->IDLE.
REQ-015 start with busy=1 SHALL be ignored; no operand capture, no state change.
REQ-016 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-017 Latency = cycles from acceptance edge to done=1; minimum 1 (one RUN cycle).
REQ-018 ALU f3: 000 add/sub, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND; non-shift ops latency 1.
REQ-019 Arithmetic modulo 2^XLEN; SLT/SLTU return 1 or 0 zero-extended.
REQ-020 Shift amount = src_b[log2(XLEN)-1:0]; upper src_b bits ignored.
REQ-021 Shifts SHALL shift by min(SHIFT_STEP, remaining) per RUN cycle; latency = max(1, ceil(shamt/SHIFT_STEP)).
REQ-022 SRA SHALL replicate bit XLEN-1 of src_a on every step.
REQ-023 BRANCH: f3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; out = zero-extended taken bit; f3 010/011 give out=0; latency 1.
REQ-024 SHADD: out = (src_a << f3[2:1]) + src_b; latency 1.
REQ-025 MUL (MUL_EN=1): out = low XLEN bits of src_a*src_b, radix-2 shift-add, one multiplier bit per cycle.
REQ-026 MUL SHALL terminate early when remaining multiplier bits are zero; latency = max(1, index of highest set bit of src_b + 1).
REQ-027 MUL with MUL_EN=0: out=0, latency 1.
REQ-028 start accepted in DONE cycle SHALL begin the new op next cycle (back-to-back, no bubble).
REQ-029 Inputs other than start SHALL be don't-care while busy=1.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, out=0, busy=0, done=0, internal counters 0, independent of clk.
REQ-031 Reset mid-operation SHALL abort it with no done pulse; first start after rst_n rises is accepted normally.
REQ-032 rst_n deassertion SHALL be synchronised externally; block takes no action on the release edge.

Verification
REQ-033 XLEN=32, STEP=1: ALU f3=101 arith_bit=1, a=0x80000000, b=4 -> done 4 cycles after accept, out=0xF8000000.
REQ-034 XLEN=32, STEP=4: SLL a=1, b=31 -> done after 8 cycles, out=0x80000000; b=0 -> done after 1, out=1.
REQ-035 MUL a=0xFFFFFFFF, b=3 -> done after 2 cycles, out=0xFFFFFFFD; b=0 -> 1 cycle, out=0.
REQ-036 BRANCH f3=100 a=0xFFFFFFFF, b=1 -> out=1; f3=110 same operands -> out=0; each latency 1.
REQ-037 Start during shift (busy=1) ignored; start in DONE cycle with SHADD f3=010 a=3 b=1 -> next done out=7, no idle cycle.
REQ-038 rst_n low mid-MUL (cycle 5 of 32) -> out=0, busy=0 asynchronously, no done; after release ADD 2+3 -> out=5.
